// File: rtl/gate_bist_ctrl.sv
// gate_bist_ctrl: BIST sweep controller for the 2-input logic_gates block; err_cnt port enabled by GATE_BIST_ERR_CNT_EN
module gate_bist_ctrl #(
   parameter int PASSES = 1,
   parameter int SETTLE = 1,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             a,
   output logic             b,
   input  logic [6:0]       gate_in,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [6:0]       fail_mask,
   output logic             first_fail_valid,
`ifdef GATE_BIST_ERR_CNT_EN
   output logic [CNT_W-1:0] err_cnt,
`endif
   output logic [1:0]       first_fail_vec
);
   localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
   localparam int PW = PASSES > 1 ? $clog2(PASSES) : 1;

   if (PASSES < 1) begin : g_bad_passes
      $error("gate_bist_ctrl: PASSES must be >= 1");
   end

   typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [1:0]      vec_q, vec_d;
   logic [PW-1:0]   pass_cnt_q, pass_cnt_d;
   logic [SW-1:0]   set_cnt_q, set_cnt_d;
   logic            a_q, a_d, b_q, b_d;
   logic            busy_q, busy_d, done_q, done_d, pass_q, pass_d;
   logic [6:0]      fail_mask_q, fail_mask_d;
   logic            ffv_q, ffv_d;
   logic [1:0]      ffvec_q, ffvec_d;
   logic [6:0]      golden, mism;
`ifdef GATE_BIST_ERR_CNT_EN
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
`endif

   // next-state and registered-output logic for the sweep FSM
   always_comb begin
      golden      = {~(a_q ^ b_q), a_q ^ b_q, ~(a_q | b_q), ~(a_q & b_q), ~a_q, a_q | b_q, a_q & b_q};
      mism        = gate_in ^ golden;
      state_d     = state_q;
      vec_d       = vec_q;
      pass_cnt_d  = pass_cnt_q;
      set_cnt_d   = set_cnt_q;
      a_d         = a_q;
      b_d         = b_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      pass_d      = pass_q;
      fail_mask_d = fail_mask_q;
      ffv_d       = ffv_q;
      ffvec_d     = ffvec_q;
`ifdef GATE_BIST_ERR_CNT_EN
      err_cnt_d   = err_cnt_q;
`endif
      case (state_q)
         S_IDLE: if (start) begin
            state_d     = S_DRIVE;
            busy_d      = 1'b1;
            pass_d      = 1'b0;
            fail_mask_d = '0;
            ffv_d       = 1'b0;
            ffvec_d     = '0;
            vec_d       = '0;
            pass_cnt_d  = '0;
`ifdef GATE_BIST_ERR_CNT_EN
            err_cnt_d   = '0;
`endif
         end
         S_DRIVE: begin
            a_d       = vec_q[1];
            b_d       = vec_q[0];
            set_cnt_d = '0;
            state_d   = SETTLE > 0 ? S_SETTLE : S_SAMPLE;
         end
         S_SETTLE: begin
            set_cnt_d = set_cnt_q + 1'b1;
            state_d   = set_cnt_q == SW'(SETTLE - 1) ? S_SAMPLE : S_SETTLE;
         end
         S_SAMPLE: begin
            fail_mask_d = fail_mask_q | mism;
            if (|mism && !ffv_q) begin
               ffv_d   = 1'b1;
               ffvec_d = vec_q;
            end
`ifdef GATE_BIST_ERR_CNT_EN
            err_cnt_d = (|mism && !(&err_cnt_q)) ? err_cnt_q + 1'b1 : err_cnt_q;
`endif
            if (vec_q == 2'd3 && pass_cnt_q == PW'(PASSES - 1)) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               pass_d  = fail_mask_d == '0;
            end else begin
               state_d    = S_DRIVE;
               vec_d      = vec_q + 2'd1;
               pass_cnt_d = vec_q == 2'd3 ? pass_cnt_q + 1'b1 : pass_cnt_q;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state and output registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         vec_q       <= '0;
         pass_cnt_q  <= '0;
         set_cnt_q   <= '0;
         a_q         <= 1'b0;
         b_q         <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_mask_q <= '0;
         ffv_q       <= 1'b0;
         ffvec_q     <= '0;
`ifdef GATE_BIST_ERR_CNT_EN
         err_cnt_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         vec_q       <= vec_d;
         pass_cnt_q  <= pass_cnt_d;
         set_cnt_q   <= set_cnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         fail_mask_q <= fail_mask_d;
         ffv_q       <= ffv_d;
         ffvec_q     <= ffvec_d;
`ifdef GATE_BIST_ERR_CNT_EN
         err_cnt_q   <= err_cnt_d;
`endif
      end
   end

   assign a                = a_q;
   assign b                = b_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign pass             = pass_q;
   assign fail_mask        = fail_mask_q;
   assign first_fail_valid = ffv_q;
   assign first_fail_vec   = ffvec_q;
`ifdef GATE_BIST_ERR_CNT_EN
   assign err_cnt          = err_cnt_q;
`endif
endmodule
